rcg_ctrl_gclk_div_gen: RTL

RCG_CTRL_GCLK_DIV_GEN -- requirements
Module: rcg_ctrl_gclk_div_gen

---
 rtl/rcg_ctrl_gclk_div_pkg.sv | 24 ++
 rtl/rcg_ctrl_gclk_div_gen_if.sv | 32 +++
 rtl/rcg_ctrl_gclk_div_cnt.sv | 31 +++
 rtl/rcg_ctrl_gclk_div_gen.sv | 134 +++++++++++++
 4 files changed

// File: rtl/rcg_ctrl_gclk_div_pkg.sv
// Shared definitions for the gated-clock divider enable generator:
// default ratio width, guard length and the ratio-update FSM state encoding.
// Optional feature macro: RCG_CTRL_GCLK_DIV_GUARD_EN (adds the GUARD state).
package rcg_ctrl_gclk_div_pkg;

   localparam int DIV_W_DEF = 8;
   localparam int GUARD_CYC = 2;

`ifdef RCG_CTRL_GCLK_DIV_GUARD_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_GUARD = 2'd2,
      ST_ACK   = 2'd3
   } div_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ACK   = 2'd3
   } div_state_e;
`endif

endpackage

// File: rtl/rcg_ctrl_gclk_div_gen_if.sv
// Ratio-update handshake bundle between a requester (master) and the
// divider enable generator (slave).
interface rcg_ctrl_gclk_div_gen_if #(
   parameter int DIV_W = 8
) ();

   logic [DIV_W-1:0] div_ratio_in;
   logic             div_upd_req;
   logic             div_upd_ack;
   logic             div_busy;
   logic             div_upd_err;
   logic [DIV_W-1:0] div_ratio_cur;

   modport master (
      output div_ratio_in,
      output div_upd_req,
      input  div_upd_ack,
      input  div_busy,
      input  div_upd_err,
      input  div_ratio_cur
   );

   modport slave (
      input  div_ratio_in,
      input  div_upd_req,
      output div_upd_ack,
      output div_busy,
      output div_upd_err,
      output div_ratio_cur
   );

endinterface

// File: rtl/rcg_ctrl_gclk_div_cnt.sv
// Phase counter for the divider: runs 0..N-1 and flags the terminal count.
// Ratios 0 and 1 both mean "no division", so every cycle is terminal.
module rcg_ctrl_gclk_div_cnt #(
   parameter int DIV_W = 8
) (
   input  logic             clk_in,
   input  logic             hgrst_n,
   input  logic [DIV_W-1:0] ratio,
   input  logic             clr,
   output logic             tc
);

   logic [DIV_W-1:0] cnt_reg;

   // Terminal count: last phase of the period, or always when not dividing.
   always_comb begin
      tc = (ratio <= DIV_W'(1)) || (cnt_reg == (ratio - DIV_W'(1)));
   end

   // Counter wraps on terminal count; clr restarts the phase on a ratio switch.
   always_ff @(posedge clk_in or negedge hgrst_n) begin
      if (!hgrst_n) begin
         cnt_reg <= '0;
      end else if (clr || tc) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + DIV_W'(1);
      end
   end

endmodule

// File: rtl/rcg_ctrl_gclk_div_gen.sv
// Clock-gate enable generator for a divided gated clock. Produces a one-cycle
// enable every N cycles and switches ratio glitch-free at a period boundary.
// Optional feature macro: RCG_CTRL_GCLK_DIV_GUARD_EN inserts a GUARD_CYC-cycle
// quiet window (enable held low, counter held) between old and new ratio.
module rcg_ctrl_gclk_div_gen
   import rcg_ctrl_gclk_div_pkg::*;
#(
   parameter int DIV_W     = DIV_W_DEF,
   parameter int RST_RATIO = 1
) (
   input  logic                     clk_in,
   input  logic                     hgrst_n,
   input  logic                     scan_mode,
   rcg_ctrl_gclk_div_gen_if.slave   upd,
   output logic                     gclk_div_cg_en,
   output logic                     gclk_div_en
);

   div_state_e       state_reg, state_next;
   logic [DIV_W-1:0] shadow_reg, shadow_next;
   logic [DIV_W-1:0] ratio_cur_reg, ratio_next;
   logic             err_reg, err_next;
   logic             cg_en_reg, cg_next;
   logic             div_en_reg;
   logic             ack_reg;
   logic             busy_reg;
   logic             cnt_clr;
   logic             tc;
`ifdef RCG_CTRL_GCLK_DIV_GUARD_EN
   logic [1:0]       guard_reg, guard_next;
`endif

   rcg_ctrl_gclk_div_cnt #(
      .DIV_W (DIV_W)
   ) cnt_u (
      .clk_in  (clk_in),
      .hgrst_n (hgrst_n),
      .ratio   (ratio_cur_reg),
      .clr     (cnt_clr),
      .tc      (tc)
   );

   // Update FSM: accept in IDLE, wait for a period boundary, switch, acknowledge.
   always_comb begin
      state_next  = state_reg;
      shadow_next = shadow_reg;
      ratio_next  = ratio_cur_reg;
      err_next    = err_reg;
      cnt_clr     = 1'b0;
      cg_next     = tc;
`ifdef RCG_CTRL_GCLK_DIV_GUARD_EN
      guard_next  = guard_reg;
`endif
      if (upd.div_upd_req) begin
         if (state_reg == ST_IDLE) begin
            shadow_next = upd.div_ratio_in;
            err_next    = 1'b0;
            state_next  = ST_DRAIN;
         end else begin
            err_next    = 1'b1;
         end
      end
      case (state_reg)
         ST_DRAIN: begin
            // Switch on the terminal edge; the old-ratio pulse still goes out.
            if (tc) begin
               ratio_next = shadow_reg;
               cnt_clr    = 1'b1;
`ifdef RCG_CTRL_GCLK_DIV_GUARD_EN
               guard_next = 2'd0;
               state_next = ST_GUARD;
`else
               state_next = ST_ACK;
`endif
            end
         end
`ifdef RCG_CTRL_GCLK_DIV_GUARD_EN
         ST_GUARD: begin
            cnt_clr    = 1'b1;
            cg_next    = 1'b0;
            guard_next = guard_reg + 2'd1;
            if (guard_reg == 2'(GUARD_CYC - 1)) begin
               state_next = ST_ACK;
            end
         end
`endif
         ST_ACK: begin
            state_next = ST_IDLE;
         end
         default: begin
         end
      endcase
   end

   // State and output registers; reset abandons any update in flight.
   always_ff @(posedge clk_in or negedge hgrst_n) begin
      if (!hgrst_n) begin
         state_reg     <= ST_IDLE;
         shadow_reg    <= DIV_W'(RST_RATIO);
         ratio_cur_reg <= DIV_W'(RST_RATIO);
         err_reg       <= 1'b0;
         cg_en_reg     <= 1'b0;
         div_en_reg    <= 1'b0;
         ack_reg       <= 1'b0;
         busy_reg      <= 1'b0;
`ifdef RCG_CTRL_GCLK_DIV_GUARD_EN
         guard_reg     <= 2'd0;
`endif
      end else begin
         state_reg     <= state_next;
         shadow_reg    <= shadow_next;
         ratio_cur_reg <= ratio_next;
         err_reg       <= err_next;
         cg_en_reg     <= cg_next;
         div_en_reg    <= (ratio_next > DIV_W'(1));
         ack_reg       <= (state_next == ST_ACK);
         busy_reg      <= (state_next != ST_IDLE);
`ifdef RCG_CTRL_GCLK_DIV_GUARD_EN
         guard_reg     <= guard_next;
`endif
      end
   end

   // Scan forces the gate open and reports "not dividing"; counters keep running.
   always_comb begin
      gclk_div_cg_en    = scan_mode | cg_en_reg;
      gclk_div_en       = ~scan_mode & div_en_reg;
      upd.div_upd_ack   = ack_reg;
      upd.div_busy      = busy_reg;
      upd.div_upd_err   = err_reg;
      upd.div_ratio_cur = ratio_cur_reg;
   end

endmodule
